// File: rtl/logic_ops_pkg.sv
// Shared definitions for the logic-op issue path: opcode width, opcode values, request record.
// Ports: none (package). Imported by logic_unit, logic_req_fifo and logic_op_sequencer.
// Modules that need other operand/tag widths declare their own request struct with the same field order.
package logic_ops_pkg;

  localparam int LOGIC_OPCODE_WIDTH = 2;

  localparam logic [LOGIC_OPCODE_WIDTH-1:0] OP_OR  = 2'd0;
  localparam logic [LOGIC_OPCODE_WIDTH-1:0] OP_AND = 2'd1;
  localparam logic [LOGIC_OPCODE_WIDTH-1:0] OP_XOR = 2'd2;

  // Default-width request record (32-bit operands, 4-bit tag).
  typedef struct packed {
    logic [LOGIC_OPCODE_WIDTH-1:0] func;
    logic [31:0]                   a;
    logic [31:0]                   b;
    logic [3:0]                    tag;
  } logic_req_t;

endpackage

// File: rtl/logic_req_fifo.sv
// Synchronous request FIFO over the {func, a, b, tag} record.
// Latency: pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full/empty come from the occupancy count.
// Ports: clk, rst (async, active-high); push/push_dat; pop/pop_dat (head); full, empty, count.
module logic_req_fifo
  import logic_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [LOGIC_OPCODE_WIDTH+2*DATA_WIDTH+TAG_WIDTH-1:0] push_dat,
  input  logic                       pop,
  output logic [LOGIC_OPCODE_WIDTH+2*DATA_WIDTH+TAG_WIDTH-1:0] pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  typedef struct packed {
    logic [LOGIC_OPCODE_WIDTH-1:0] func;
    logic [DATA_WIDTH-1:0]         a;
    logic [DATA_WIDTH-1:0]         b;
    logic [TAG_WIDTH-1:0]          tag;
  } req_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  req_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit: OR / AND / XOR on two operands.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: func/a/b in; result out (0 for undefined opcodes); illegal out (1 for undefined opcodes).
module logic_unit
  import logic_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [LOGIC_OPCODE_WIDTH-1:0] func,
  input  logic [DATA_WIDTH-1:0]         a,
  input  logic [DATA_WIDTH-1:0]         b,
  output logic [DATA_WIDTH-1:0]         result,
  output logic                          illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (func)
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// Buffers tagged logic-op requests and issues one per cycle through logic_unit into a result register.
// Latency: request accepted at edge N into an empty FIFO with a free output stage is valid after edge N+1.
// Backpressure: req_ready = buffer not full (registered state only); result held stable while res_ready low.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_func/req_a/req_b/req_tag;
//        res_valid/res_ready/res_data/res_tag/res_illegal; fifo_count.
// Option: LOGIC_SEQ_STATS_EN adds op_count[31:0] and illegal_count[15:0] issue counters (wrap at all-ones).
module logic_op_sequencer
  import logic_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [LOGIC_OPCODE_WIDTH-1:0] req_func,
  input  logic [DATA_WIDTH-1:0]         req_a,
  input  logic [DATA_WIDTH-1:0]         req_b,
  input  logic [TAG_WIDTH-1:0]          req_tag,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic [TAG_WIDTH-1:0]          res_tag,
  output logic                          res_illegal,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef LOGIC_SEQ_STATS_EN
  ,
  output logic [31:0]                   op_count,
  output logic [15:0]                   illegal_count
`endif
);

  typedef struct packed {
    logic [LOGIC_OPCODE_WIDTH-1:0] func;
    logic [DATA_WIDTH-1:0]         a;
    logic [DATA_WIDTH-1:0]         b;
    logic [TAG_WIDTH-1:0]          tag;
  } req_t;

  req_t                  push_dat;
  req_t                  head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  issue;
  logic [DATA_WIDTH-1:0] lu_result;
  logic                  lu_illegal;

  assign push_dat  = '{func: req_func, a: req_a, b: req_b, tag: req_tag};
  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  // Issue whenever the output register is empty or being emptied this cycle.
  assign issue     = !fifo_empty && (!res_valid || res_ready);

  logic_req_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (issue),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  logic_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_logic_unit (
    .func    (head.func),
    .a       (head.a),
    .b       (head.b),
    .result  (lu_result),
    .illegal (lu_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_tag     <= '0;
      res_illegal <= 1'b0;
    end else if (issue) begin
      res_valid   <= 1'b1;
      res_data    <= lu_result;
      res_tag     <= head.tag;
      res_illegal <= lu_illegal;
    end else if (res_valid && res_ready) begin
      res_valid   <= 1'b0;
    end
  end

`ifdef LOGIC_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count      <= '0;
      illegal_count <= '0;
    end else if (issue) begin
      op_count <= op_count + 1'b1;
      if (lu_illegal) illegal_count <= illegal_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_op_sequencer.sv
module tb_logic_op_sequencer;
  import logic_ops_pkg::*;

  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                          clk;
  logic                          rst;
  logic                          req_valid;
  logic                          req_ready;
  logic [LOGIC_OPCODE_WIDTH-1:0] req_func;
  logic [DW-1:0]                 req_a;
  logic [DW-1:0]                 req_b;
  logic [TW-1:0]                 req_tag;
  logic                          res_valid;
  logic                          res_ready;
  logic [DW-1:0]                 res_data;
  logic [TW-1:0]                 res_tag;
  logic                          res_illegal;
  logic [CW-1:0]                 fifo_count;
`ifdef LOGIC_SEQ_STATS_EN
  logic [31:0]                   op_count;
  logic [15:0]                   illegal_count;
`endif

  logic_op_sequencer #(
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_func    (req_func),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_tag     (res_tag),
    .res_illegal (res_illegal),
    .fifo_count  (fifo_count)
`ifdef LOGIC_SEQ_STATS_EN
    ,
    .op_count      (op_count),
    .illegal_count (illegal_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each accepted request becomes one expected result, returned strictly in order.
  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;
  int   n_pushed;
  int   n_ill;
  logic req_fired;
  logic prev_stall;
  logic [DW-1:0] prev_d;
  logic [TW-1:0] prev_t;
  logic          prev_ill;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [LOGIC_OPCODE_WIDTH-1:0] f,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [TW-1:0] t);
    exp_t e;
    e.t   = t;
    e.ill = 1'b0;
    if (f == OP_OR)       e.d = a | b;
    else if (f == OP_AND) e.d = a & b;
    else if (f == OP_XOR) e.d = a ^ b;
    else begin
      e.d   = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // One clock: observe handshakes at the falling edge, then advance to just after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", 64'(res_data), 64'(prev_d));
      chk("hold_tag", 64'(res_tag), 64'(prev_t));
      chk("hold_illegal", 64'(res_illegal), 64'(prev_ill));
    end
    if (res_valid && res_ready) begin
      chk("result_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("res_data", 64'(res_data), 64'(e.d));
        chk("res_tag", 64'(res_tag), 64'(e.t));
        chk("res_illegal", 64'(res_illegal), 64'(e.ill));
      end
    end
    prev_stall = res_valid && !res_ready;
    prev_d     = res_data;
    prev_t     = res_tag;
    prev_ill   = res_illegal;
    req_fired  = req_valid && req_ready && !rst;
    if (req_fired) begin
      e = model(req_func, req_a, req_b, req_tag);
      exp_q.push_back(e);
      n_pushed++;
      if (e.ill) n_ill++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [LOGIC_OPCODE_WIDTH-1:0] f, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TW-1:0] t, output int waited);
    req_valid = 1'b1;
    req_func  = f;
    req_a     = a;
    req_b     = b;
    req_tag   = t;
    waited    = 0;
    req_fired = 1'b0;
    while (!req_fired && waited < 20) begin
      step();
      waited++;
    end
    chk("push_accepted", 64'(req_fired), 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = 1'b0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || res_valid) && n < 100) begin
      step();
      n++;
    end
    chk("drain_done", 64'(exp_q.size() == 0 && !res_valid), 64'd1);
    chk("drain_count", 64'(fifo_count), 64'd0);
`ifdef LOGIC_SEQ_STATS_EN
    chk("op_count", 64'(op_count), 64'(n_pushed));
    chk("illegal_count", 64'(illegal_count), 64'(n_ill));
`endif
  endtask

  initial begin
    logic [LOGIC_OPCODE_WIDTH-1:0] funcs [3];
    logic [DW-1:0] cap_d;
    logic [TW-1:0] cap_t;
    logic          cap_ill;
    int w;

    n_vec = 0; n_err = 0; n_pushed = 0; n_ill = 0;
    req_fired = 1'b0; prev_stall = 1'b0;
    prev_d = '0; prev_t = '0; prev_ill = 1'b0;
    funcs[0] = OP_OR; funcs[1] = OP_XOR; funcs[2] = OP_AND;
    rst = 1'b1; req_valid = 1'b0; req_func = '0; req_a = '0; req_b = '0; req_tag = '0;
    res_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_tag", 64'(res_tag), 64'd0);
    chk("rst_res_illegal", 64'(res_illegal), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single AND op, one-cycle latency
    res_ready = 1'b1;
    push_op(OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd3, w);
    chk("single_count_after_accept", 64'(fifo_count), 64'd1);
    chk("single_not_yet_valid", 64'(res_valid), 64'd0);
    step();
    chk("single_valid", 64'(res_valid), 64'd1);
    chk("single_data", 64'(res_data), 64'h00F0_000F);
    chk("single_tag", 64'(res_tag), 64'd3);
    chk("single_illegal", 64'(res_illegal), 64'd0);
    drain();

    // Fill under backpressure: 1 issued + 4 buffered, 6th request held
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_op(funcs[$urandom_range(0, 2)], $urandom(), $urandom(), TW'(i), w);
    chk("fill_count", 64'(fifo_count), 64'd4);
    chk("fill_req_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b1; req_func = OP_OR; req_a = $urandom(); req_b = $urandom(); req_tag = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_no_accept", 64'(req_fired), 64'd0);
      chk("full_count_hold", 64'(fifo_count), 64'd4);
    end
    res_ready = 1'b1;
    step();
    chk("full_pop_no_push", 64'(req_fired), 64'd0);
    chk("full_pop_count", 64'(fifo_count), 64'd3);
    chk("full_ready_next", 64'(req_ready), 64'd1);
    step();
    chk("push_pop_accept", 64'(req_fired), 64'd1);
    chk("push_pop_count", 64'(fifo_count), 64'd3);
    drain();

    // Back-to-back with res_ready high
    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_op(funcs[i % 3], $urandom(), $urandom(), TW'(i), w);
      chk("b2b_no_wait", 64'(w), 64'd1);
      chk("b2b_count_le1", 64'(fifo_count <= 1), 64'd1);
      if (i > 0) chk("b2b_res_valid", 64'(res_valid), 64'd1);
    end
    drain();

    // Illegal opcode
    push_op(2'd3, $urandom(), $urandom(), 4'd7, w);
    step();
    chk("ill_valid", 64'(res_valid), 64'd1);
    chk("ill_data", 64'(res_data), 64'd0);
    chk("ill_flag", 64'(res_illegal), 64'd1);
    chk("ill_tag", 64'(res_tag), 64'd7);
`ifdef LOGIC_SEQ_STATS_EN
    chk("ill_count_one", 64'(illegal_count), 64'd1);
`endif
    drain();

    // Backpressure hold for 10 cycles
    res_ready = 1'b0;
    push_op(OP_XOR, $urandom(), $urandom(), 4'hA, w);
    step();
    chk("bp_valid", 64'(res_valid), 64'd1);
    cap_d = res_data; cap_t = res_tag; cap_ill = res_illegal;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid_hold", 64'(res_valid), 64'd1);
      chk("bp_data_hold", 64'(res_data), 64'(cap_d));
      chk("bp_tag_hold", 64'(res_tag), 64'(cap_t));
      chk("bp_ill_hold", 64'(res_illegal), 64'(cap_ill));
    end
    drain();

    // Reset mid-burst
    res_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      push_op(funcs[i % 3], $urandom(), $urandom(), TW'(i), w);
    chk("mid_count", 64'(fifo_count), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    exp_q.delete();
    n_pushed = 0; n_ill = 0; prev_stall = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_no_stale", 64'(res_valid), 64'd0);
    end
`ifdef LOGIC_SEQ_STATS_EN
    chk("mid_op_count_zero", 64'(op_count), 64'd0);
`endif

    // Randomized traffic, including illegal opcodes and random backpressure
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_func  = LOGIC_OPCODE_WIDTH'($urandom_range(0, 3));
      req_a     = $urandom();
      req_b     = $urandom();
      req_tag   = TW'($urandom());
      res_ready = ($urandom_range(0, 3) != 0);
      step();
      chk("rand_ready_rule", 64'(req_ready), 64'(fifo_count != DEPTH));
      chk("rand_count_le_depth", 64'(fifo_count <= DEPTH), 64'd1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
